// File: rtl/quality_sorter_pkg.sv
// Shared types for the quality sorter: diverter gate codes, FSM states and
// the priority classifier that maps result pulses onto a gate code.
package quality_sorter_pkg;

    typedef enum logic [1:0] {
        GATE_NONE = 2'b00,
        GATE_LOW  = 2'b01,
        GATE_MED  = 2'b10,
        GATE_HIGH = 2'b11
    } gate_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTUATE = 2'b01,
        SETTLE  = 2'b10
    } sorter_state_t;

    // High beats medium beats low when several pulses arrive together.
    function automatic gate_code_t classify(input logic low, input logic med, input logic high);
        if (high)     return GATE_HIGH;
        else if (med) return GATE_MED;
        else if (low) return GATE_LOW;
        else          return GATE_NONE;
    endfunction

endpackage

// File: rtl/qs_fifo.sv
// Small synchronous FIFO of 2-bit class codes. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module qs_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [1:0]    head
);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/quality_sorter.sv
// Queues classifier results and drives the three-way diverter gate, one item
// per HOLD_CYCLES+2 cycles. Tallies exist only with QUALITY_SORTER_TALLY_EN.
module quality_sorter
    import quality_sorter_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             low_i,
    input  logic             medium_i,
    input  logic             high_i,
    input  logic             clear_i,
    output logic [1:0]       gate_o,
    output logic             gate_active_o,
    output logic [CNT_W-1:0] cnt_low_o,
    output logic [CNT_W-1:0] cnt_med_o,
    output logic [CNT_W-1:0] cnt_high_o,
    output logic [LW-1:0]    fifo_level_o,
    output logic             overflow_o,
    output logic             multi_err_o
);

    sorter_state_t state;
    gate_code_t    gate_q;
    gate_code_t    ev_code;
    logic [7:0]    hold_cnt;
    logic          event_v;
    logic          multi_v;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;
    logic [1:0]    head;

    assign event_v = low_i | medium_i | high_i;
    assign multi_v = (low_i & medium_i) | (low_i & high_i) | (medium_i & high_i);
    assign ev_code = classify(low_i, medium_i, high_i);
    assign pop     = (state == IDLE) && !fifo_empty;
    assign drop    = event_v && fifo_full && !pop;
    assign gate_o  = gate_q;

    qs_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (event_v),
        .pop   (pop),
        .data  (ev_code),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o),
        .head  (head)
    );

    // The hold counter is loaded with HOLD_CYCLES-1 so the gate stays on
    // for exactly HOLD_CYCLES cycles including the load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gate_q        <= GATE_NONE;
            gate_active_o <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state         <= ACTUATE;
                        gate_q        <= gate_code_t'(head);
                        gate_active_o <= 1'b1;
                        hold_cnt      <= 8'(HOLD_CYCLES - 1);
                    end
                end
                ACTUATE: begin
                    if (hold_cnt == '0) begin
                        state         <= SETTLE;
                        gate_q        <= GATE_NONE;
                        gate_active_o <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o  <= 1'b0;
            multi_err_o <= 1'b0;
        end else if (clear_i) begin
            overflow_o  <= 1'b0;
            multi_err_o <= 1'b0;
        end else begin
            if (drop)    overflow_o  <= 1'b1;
            if (multi_v) multi_err_o <= 1'b1;
        end
    end

`ifdef QUALITY_SORTER_TALLY_EN
    logic push_ok;
    assign push_ok = event_v && (!fifo_full || pop);

    // Clear takes precedence over a coincident accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_low_o  <= '0;
            cnt_med_o  <= '0;
            cnt_high_o <= '0;
        end else if (clear_i) begin
            cnt_low_o  <= '0;
            cnt_med_o  <= '0;
            cnt_high_o <= '0;
        end else if (push_ok) begin
            case (ev_code)
                GATE_LOW:  if (cnt_low_o  != '1) cnt_low_o  <= cnt_low_o  + 1'b1;
                GATE_MED:  if (cnt_med_o  != '1) cnt_med_o  <= cnt_med_o  + 1'b1;
                GATE_HIGH: if (cnt_high_o != '1) cnt_high_o <= cnt_high_o + 1'b1;
                default:   ;
            endcase
        end
    end
`else
    assign cnt_low_o  = '0;
    assign cnt_med_o  = '0;
    assign cnt_high_o = '0;
`endif

endmodule

// File: tb/tb_quality_sorter.sv
// Directed bench for quality_sorter (CNT_W=2, HOLD_CYCLES=4, FIFO_DEPTH=4);
// tally expectations follow QUALITY_SORTER_TALLY_EN.
module tb_quality_sorter;

`ifdef QUALITY_SORTER_TALLY_EN
    localparam bit TALLY = 1'b1;
`else
    localparam bit TALLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       low_i = 1'b0;
    logic       medium_i = 1'b0;
    logic       high_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [1:0] gate_o;
    logic       gate_active_o;
    logic [1:0] cnt_low_o;
    logic [1:0] cnt_med_o;
    logic [1:0] cnt_high_o;
    logic [2:0] fifo_level_o;
    logic       overflow_o;
    logic       multi_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quality_sorter #(.CNT_W(2), .HOLD_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .low_i         (low_i),
        .medium_i      (medium_i),
        .high_i        (high_i),
        .clear_i       (clear_i),
        .gate_o        (gate_o),
        .gate_active_o (gate_active_o),
        .cnt_low_o     (cnt_low_o),
        .cnt_med_o     (cnt_med_o),
        .cnt_high_o    (cnt_high_o),
        .fifo_level_o  (fifo_level_o),
        .overflow_o    (overflow_o),
        .multi_err_o   (multi_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        total++; if (gate_o !== 2'b00) begin bad++; $display("FAIL reset_gate got=%b want=00", gate_o); end
        total++; if (gate_active_o !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", gate_active_o); end
        total++; if ({cnt_low_o, cnt_med_o, cnt_high_o} !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%b want=0", {cnt_low_o, cnt_med_o, cnt_high_o}); end
        total++; if (fifo_level_o !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level_o); end
        total++; if ({overflow_o, multi_err_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {overflow_o, multi_err_o}); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_high();
        logic [1:0] exp_cnt;
        exp_cnt = TALLY ? 2'd1 : 2'd0;
        high_i = 1'b1;
        tick();
        high_i = 1'b0;
        total++; if (fifo_level_o !== 3'd1) begin bad++; $display("FAIL single_level got=%0d want=1", fifo_level_o); end
        total++; if (gate_o !== 2'b00) begin bad++; $display("FAIL single_gate_early got=%b want=00", gate_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (gate_o !== 2'b11 || gate_active_o !== 1'b1) begin bad++; $display("FAIL single_gate_on cyc%0d got=%b/%b want=11/1", i, gate_o, gate_active_o); end
        end
        tick();
        total++; if (gate_o !== 2'b00 || gate_active_o !== 1'b0) begin bad++; $display("FAIL single_gate_off got=%b/%b want=00/0", gate_o, gate_active_o); end
        total++; if (cnt_high_o !== exp_cnt) begin bad++; $display("FAIL single_cnt_high got=%0d want=%0d", cnt_high_o, exp_cnt); end
        idle(3);
    endtask

    task automatic test_two_classes();
        logic [1:0] exp_seq [11];
        logic [1:0] exp_cnt;
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        exp_cnt = TALLY ? 2'd1 : 2'd0;
        do_clear();
        medium_i = 1'b1;
        tick();
        medium_i = 1'b0;
        low_i = 1'b1;
        tick();
        low_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            total++; if (gate_o !== exp_seq[i]) begin bad++; $display("FAIL two_seq cyc%0d got=%b want=%b", i, gate_o, exp_seq[i]); end
            tick();
        end
        total++; if (cnt_med_o !== exp_cnt) begin bad++; $display("FAIL two_cnt_med got=%0d want=%0d", cnt_med_o, exp_cnt); end
        total++; if (cnt_low_o !== exp_cnt) begin bad++; $display("FAIL two_cnt_low got=%0d want=%0d", cnt_low_o, exp_cnt); end
        idle(2);
    endtask

    task automatic test_overflow();
        int rises;
        int on_cycles;
        logic [1:0] prev;
        logic [1:0] exp_cnt;
        exp_cnt = TALLY ? 2'd3 : 2'd0;
        rises = 0;
        on_cycles = 0;
        prev = gate_o;
        do_clear();
        for (int cyc = 0; cyc < 40; cyc++) begin
            high_i = (cyc < 6);
            tick();
            if (cyc == 4) begin
                total++; if (overflow_o !== 1'b0 || fifo_level_o !== 3'd4) begin bad++; $display("FAIL ovf_prefull got=%b/%0d want=0/4", overflow_o, fifo_level_o); end
            end
            if (cyc == 5) begin
                total++; if (overflow_o !== 1'b1 || fifo_level_o !== 3'd4) begin bad++; $display("FAIL ovf_drop got=%b/%0d want=1/4", overflow_o, fifo_level_o); end
            end
            if (gate_o == 2'b11) on_cycles++;
            if (gate_o == 2'b11 && prev != 2'b11) rises++;
            prev = gate_o;
        end
        high_i = 1'b0;
        total++; if (rises !== 5) begin bad++; $display("FAIL ovf_pulses got=%0d want=5", rises); end
        total++; if (on_cycles !== 20) begin bad++; $display("FAIL ovf_on_cycles got=%0d want=20", on_cycles); end
        total++; if (cnt_high_o !== exp_cnt) begin bad++; $display("FAIL ovf_cnt_high got=%0d want=%0d", cnt_high_o, exp_cnt); end
        total++; if (fifo_level_o !== 3'd0 || overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%0d/%b want=0/1", fifo_level_o, overflow_o); end
    endtask

    task automatic test_multi();
        logic [1:0] exp_cnt;
        exp_cnt = TALLY ? 2'd1 : 2'd0;
        do_clear();
        high_i = 1'b1;
        low_i = 1'b1;
        tick();
        high_i = 1'b0;
        low_i = 1'b0;
        total++; if (multi_err_o !== 1'b1) begin bad++; $display("FAIL multi_flag got=%b want=1", multi_err_o); end
        tick();
        total++; if (gate_o !== 2'b11) begin bad++; $display("FAIL multi_gate got=%b want=11", gate_o); end
        total++; if (cnt_high_o !== exp_cnt) begin bad++; $display("FAIL multi_cnt_high got=%0d want=%0d", cnt_high_o, exp_cnt); end
        total++; if (cnt_low_o !== 2'd0) begin bad++; $display("FAIL multi_cnt_low got=%0d want=0", cnt_low_o); end
        idle(6);
    endtask

    task automatic test_saturate_clear();
        logic [1:0] exp_sat;
        logic [1:0] exp_one;
        exp_sat = TALLY ? 2'd3 : 2'd0;
        exp_one = TALLY ? 2'd1 : 2'd0;
        do_clear();
        low_i = 1'b1;
        idle(6);
        low_i = 1'b0;
        total++; if (cnt_low_o !== exp_sat) begin bad++; $display("FAIL sat_cnt_low got=%0d want=%0d", cnt_low_o, exp_sat); end
        total++; if (overflow_o !== 1'b1 || fifo_level_o !== 3'd4) begin bad++; $display("FAIL sat_ovf got=%b/%0d want=1/4", overflow_o, fifo_level_o); end
        do_clear();
        total++; if (cnt_low_o !== 2'd0 || overflow_o !== 1'b0 || multi_err_o !== 1'b0) begin bad++; $display("FAIL clr_state got=%0d/%b/%b want=0/0/0", cnt_low_o, overflow_o, multi_err_o); end
        total++; if (fifo_level_o !== 3'd4) begin bad++; $display("FAIL clr_level got=%0d want=4", fifo_level_o); end
        tick();
        total++; if (gate_o !== 2'b01 || fifo_level_o !== 3'd3) begin bad++; $display("FAIL clr_continue got=%b/%0d want=01/3", gate_o, fifo_level_o); end
        idle(30);
        low_i = 1'b1;
        clear_i = 1'b1;
        tick();
        low_i = 1'b0;
        clear_i = 1'b0;
        total++; if (cnt_low_o !== 2'd0 || fifo_level_o !== 3'd1) begin bad++; $display("FAIL clr_wins got=%0d/%0d want=0/1", cnt_low_o, fifo_level_o); end
        low_i = 1'b1;
        tick();
        low_i = 1'b0;
        total++; if (cnt_low_o !== exp_one || fifo_level_o !== 3'd1) begin bad++; $display("FAIL post_clr_push got=%0d/%0d want=%0d/1", cnt_low_o, fifo_level_o, exp_one); end
        idle(15);
    endtask

    task automatic test_reset_mid();
        high_i = 1'b1;
        tick();
        high_i = 1'b0;
        medium_i = 1'b1;
        tick();
        medium_i = 1'b0;
        tick();
        total++; if (gate_o !== 2'b11 || fifo_level_o !== 3'd1) begin bad++; $display("FAIL rstmid_pre got=%b/%0d want=11/1", gate_o, fifo_level_o); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (gate_o !== 2'b00 || gate_active_o !== 1'b0) begin bad++; $display("FAIL rstmid_gate got=%b/%b want=00/0", gate_o, gate_active_o); end
        total++; if (fifo_level_o !== 3'd0) begin bad++; $display("FAIL rstmid_level got=%0d want=0", fifo_level_o); end
        tick();
        rst_n = 1'b1;
        idle(3);
        total++; if (gate_o !== 2'b00 || fifo_level_o !== 3'd0) begin bad++; $display("FAIL rstmid_after got=%b/%0d want=00/0", gate_o, fifo_level_o); end
    endtask

    initial begin
        test_reset();
        test_single_high();
        test_two_classes();
        test_overflow();
        test_multi();
        test_saturate_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quality_sorter.md
Name: quality_sorter

Overview:
- Downstream stage of the quality-classification FSM.
- Consumes its one-hot result pulses (low/medium/high) and queues them in a small FIFO.
- Drives a three-way diverter gate for a fixed hold time per item.
- Keeps saturating per-class tallies for the operator display.

Parameters:
- CNT_W, 8: width of each per-class tally counter.
- HOLD_CYCLES, 4: cycles gate_o stays on a bin per item (legal range 1..255).
- FIFO_DEPTH, 4: pending-result queue depth (power of two, at least 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- low_i  in  1  low-quality result pulse from the classifier
- medium_i  in  1  medium-quality result pulse
- high_i  in  1  high-quality result pulse
- clear_i  in  1  synchronous clear of tallies and sticky flags
- gate_o  out  2  diverter code: 00 none, 01 low bin, 10 medium bin, 11 high bin
- gate_active_o  out  1  high while the gate is held on a bin
- cnt_low_o  out  CNT_W  tally of accepted low results
- cnt_med_o  out  CNT_W  tally of accepted medium results
- cnt_high_o  out  CNT_W  tally of accepted high results
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  number of queued results
- overflow_o  out  1  sticky: a result was dropped because the FIFO was full
- multi_err_o  out  1  sticky: more than one input was high in the same cycle

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, all counters 0.
- Event definition: an event occurs in any cycle where low_i, medium_i or high_i is high.
- Event class: priority high > medium > low.
- If two or more inputs are high in the same cycle, multi_err_o sets, and the event is still processed with the priority class.
- Push: at each edge with an event, the class code is written to the FIFO if it is not full.
- Full FIFO:
  - The push is dropped and overflow_o sets, unless a pop occurs in the same cycle.
  - With a same-cycle pop the push is accepted and the level is unchanged.
- Tallies:
  - The class counter increments only on an accepted push and saturates at 2^CNT_W-1.
  - A dropped push does not count.
- States:
  - IDLE → ACTUATE when the FIFO is non-empty: pop the head, load gate_o with its code, load the hold counter with HOLD_CYCLES-1, set gate_active_o.
  - ACTUATE:
    - Decrement the hold counter each cycle.
    - At 0, go to SETTLE with gate_o=00 and gate_active_o=0.
    - gate_o is therefore on for exactly HOLD_CYCLES cycles.
  - SETTLE → IDLE after one cycle, which guarantees at least one gap cycle between items.
- Latency: an event sampled at edge k into an empty FIFO in state IDLE gives gate_o valid after edge k+1. fifo_level_o reads 1 for one cycle in between.
- Back-to-back items: each item occupies HOLD_CYCLES+2 cycles (ACTUATE, SETTLE, IDLE).
- clear_i:
  - Zeroes the tallies and clears overflow_o and multi_err_o.
  - The FIFO, state and gate are unaffected.
  - If clear_i coincides with an accepted push, the clear wins and the counter reads 0.
- Reset mid-operation: gate_o drops to 00 immediately (asynchronous); queued items are lost.

Optional Feature:
- Macro: QUALITY_SORTER_TALLY_EN.
- Defined: tally counters present as described.
- Undefined: no counter flops; cnt_low_o, cnt_med_o and cnt_high_o are tied to 0; clear_i affects only the sticky flags.

Decomposition:
- Package quality_sorter_pkg holds:
  - enum gate_code_t: GATE_NONE=2'b00, GATE_LOW=2'b01, GATE_MED=2'b10, GATE_HIGH=2'b11.
  - enum sorter_state_t: IDLE, ACTUATE, SETTLE.
- One sub-module: qs_fifo, a synchronous FIFO with width 2 and depth FIFO_DEPTH.
  - Inputs: push, pop, data.
  - Outputs: full, empty, level, head data.
  - Same-cycle push and pop are allowed when full.

Test Plan:
- After reset, a single high_i pulse → gate_o=11 for exactly 4 cycles starting 2 edges later, then 00; cnt_high_o=1.
- medium_i and low_i pulses on consecutive cycles → gate sequence 10 (4 cycles), 00 (2 cycles), 01 (4 cycles); cnt_med_o=1, cnt_low_o=1.
- Six high_i pulses on consecutive cycles with FIFO_DEPTH=4 → 5 accepted (one is popped first), 1 dropped; overflow_o=1; cnt_high_o=5; gate pulses on bin 11 five times.
- high_i and low_i both high in one cycle → multi_err_o=1, gate_o=11, cnt_high_o increments, cnt_low_o unchanged.
- Set CNT_W=2 and send 5 low results → cnt_low_o saturates at 3. Then clear_i → counts and sticky flags read 0, while any queued gate activity continues.
- Assert rst_n low during ACTUATE → gate_o=00, gate_active_o=0 and fifo_level_o=0 immediately.
